adc_fifo_wb_reader: RTL and testbench
=====================================

Name: adc_fifo_wb_reader

Overview:
- Wishbone classic slave that forms the consumer (pop) end of adc_stream_fifo.
- Firmware reads the DATA register to pop one 32-bit ADC word. LEVEL and STATUS registers expose fill level, the overrun state and a read-underflow flag.
- Writing STATUS drives the FIFO's overrun_clear.
- Sits between the Caravel Wishbone bus and the ADC stream FIFO, in the same clock domain.

Parameters:
- LEVEL_W, 4: width of level_words from the FIFO (log2(DEPTH_WORDS)+1).
- EMPTY_VALUE, 32'h0000_0000: value returned by a DATA read when the FIFO is empty.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, active-high, synchronous.
- wb_cyc_i  input  1  Wishbone cycle.
- wb_stb_i  input  1  Wishbone strobe; block is selected when cyc & stb.
- wb_we_i  input  1  write enable.
- wb_adr_i  input  4  byte offset; decode on [3:2].
- wb_dat_i  input  32  write data.
- wb_sel_i  input  4  byte selects; a write acts only if wb_sel_i[0]=1.
- wb_dat_o  output  32  read data, registered.
- wb_ack_o  output  1  acknowledge, registered.
- pop_valid  input  1  FIFO has a word at its head (show-ahead).
- pop_data  input  32  head word.
- pop_ready  output  1  pop strobe to the FIFO.
- level_words  input  LEVEL_W  FIFO occupancy.
- overrun_sticky  input  1  FIFO overrun flag.
- overrun_clear  output  1  single-cycle clear pulse to the FIFO.

Behaviour:
- Register map:
  - 0x0 DATA (RO, read pops one word).
  - 0x4 LEVEL (RO, zero-extended level_words).
  - 0x8 STATUS: bit0 overrun_sticky, bit1 pop_valid, bit2 underflow_sticky. Writing 1 to bit0 clears overrun; writing 1 to bit2 clears underflow.
  - 0xC: reads 0 (unless the optional feature is compiled in); writes ignored.
- Request condition: req = cyc & stb & !ack_q. Every request is acknowledged exactly one cycle later (ack_q pulses for 1 cycle). Back-to-back requests therefore complete at most every 2 cycles.
- pop_ready = req & !we & adr[3:2]==0 & pop_valid. It is combinational and pops on the same edge that sets ack_q. Exactly one pop per DATA read.
- DATA read with pop_valid=1: wb_dat_o <= pop_data on the same edge.
- DATA read with pop_valid=0: wb_dat_o <= EMPTY_VALUE, underflow_sticky <= 1, no pop.
- LEVEL and STATUS reads capture values at the request edge.
- STATUS write, wb_sel_i[0]=1, wb_dat_i[0]=1: overrun_clear = 1 for exactly the request cycle. It is combinational from req, so the pulse width is 1 because ack_q blocks a repeat.
- STATUS write with wb_dat_i[2]=1: underflow_sticky <= 0. If an underflow-setting read occurs in the same cycle, set wins. This cannot happen on a single bus, but the rule is still required.
- Writes to DATA or LEVEL: acknowledged, no effect.
- If cyc or stb deasserts while ack_q=1, the transaction still completes. A stalled master (stb held) is not re-served until ack_q has cleared.
- Reset values: wb_ack_o=0, wb_dat_o=0, underflow_sticky=0. pop_ready and overrun_clear are 0 while rst=1, being gated by !rst.
- Reset asserted mid-transaction: the pending ack is dropped, no pop occurs, and no clear pulse is issued.

Optional Feature:
- Macro: ADC_FIFO_READER_CNT_EN.
- Defined: adds a 32-bit pop counter at 0xC. It increments on every pop_ready, wraps from 0xFFFF_FFFF to 0, and resets to 0. Any write to 0xC with wb_sel_i[0]=1 clears it; a pop in the same cycle as the clear gives a count of 1.
- Undefined: 0xC reads 0 and there is no counter logic.

Decomposition:
- Package adc_fifo_reader_pkg holds:
  - Register offsets: ADC_RD_DATA_OFS=4'h0, ADC_RD_LEVEL_OFS=4'h4, ADC_RD_STATUS_OFS=4'h8, ADC_RD_CNT_OFS=4'hC.
  - STATUS bit indices: STAT_OVR=0, STAT_VALID=1, STAT_UNF=2.
- No sub-module. It is a single flat module; the register decode is too small to split.

Test Plan:
- Push 3 words A5A5_0000..0002 into the FIFO, then issue 3 DATA reads -> wb_dat_o returns 0000, 0001, 0002 in order. Each ack comes 1 cycle after stb, and level goes 3→2→1→0.
- DATA read on an empty FIFO -> wb_dat_o=0000_0000, no pop_ready pulse, STATUS reads 0x4. Write 0x4 to STATUS -> STATUS reads 0x0.
- Fill an 8-deep FIFO and push once more -> LEVEL reads 8 and STATUS reads 0x3. Write 0x1 to STATUS -> overrun_clear is high for exactly 1 cycle and STATUS then reads 0x2.
- Master holds stb high for 6 cycles on DATA with 5 words queued -> ack pattern is 0,1,0,1,0,1, giving exactly 3 pops and level 5→2.
- Assert rst in the cycle of a DATA request -> no ack, no pop, and level is unchanged.
- With ADC_FIFO_READER_CNT_EN: 4 DATA reads -> 0xC reads 4. Write 0xC -> it reads 0. Without the macro -> 0xC always reads 0.

Source files
------------

// File: rtl/adc_fifo_reader_pkg.sv
// Shared register map and STATUS bit positions for the ADC FIFO Wishbone reader.
// Latency: n/a (constants only).
// Backpressure: n/a.
package adc_fifo_reader_pkg;

    // Byte offsets of the reader registers; decode uses address bits [3:2].
    localparam logic [3:0] ADC_RD_DATA_OFS   = 4'h0;
    localparam logic [3:0] ADC_RD_LEVEL_OFS  = 4'h4;
    localparam logic [3:0] ADC_RD_STATUS_OFS = 4'h8;
    localparam logic [3:0] ADC_RD_CNT_OFS    = 4'hC;

    // STATUS register bit indices.
    localparam int STAT_OVR   = 0;
    localparam int STAT_VALID = 1;
    localparam int STAT_UNF   = 2;

    // Map a raw Wishbone byte address onto the word-aligned register offset.
    function automatic logic [3:0] reg_ofs(input logic [3:0] adr);
        return {adr[3:2], 2'b00};
    endfunction

endpackage

// File: rtl/adc_fifo_wb_reader.sv
// Wishbone classic slave on the pop side of adc_stream_fifo: DATA pops a word, LEVEL/STATUS report state.
// Latency: every request is acknowledged exactly one cycle later; read data is registered on the request edge.
// Backpressure: one pop per DATA read, none when the FIFO is empty; a held strobe is served every other cycle.
// Build option: define ADC_FIFO_READER_CNT_EN to add a clearable 32-bit pop counter at offset 0xC.
module adc_fifo_wb_reader
    import adc_fifo_reader_pkg::*;
#(
    parameter int          LEVEL_W     = 4,
    parameter logic [31:0] EMPTY_VALUE = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [3:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    input  logic               pop_valid,
    input  logic [31:0]        pop_data,
    output logic               pop_ready,
    input  logic [LEVEL_W-1:0] level_words,
    input  logic               overrun_sticky,
    output logic               overrun_clear
);

    logic        ack_q;
    logic [31:0] dat_q;
    logic        unf_q;

    logic        req;
    logic        rd_req;
    logic        wr_en;
    logic [3:0]  ofs;
    logic        sel_data;
    logic        sel_status;
    logic        unf_set;
    logic        unf_clr;
    logic [31:0] rd_val;

    // Address bits [1:0], upper byte selects and unused write-data bits carry no meaning here.
    logic        unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:3], wb_dat_i[1]};

    // A request is served once; the registered ack masks a still-held strobe for one cycle.
    // Gating with rst keeps pop_ready and overrun_clear quiet while reset is applied.
    assign ofs        = reg_ofs(wb_adr_i);
    assign req        = wb_cyc_i & wb_stb_i & ~ack_q & ~rst;
    assign rd_req     = req & ~wb_we_i;
    assign wr_en      = req & wb_we_i & wb_sel_i[0];
    assign sel_data   = (ofs == ADC_RD_DATA_OFS);
    assign sel_status = (ofs == ADC_RD_STATUS_OFS);

    // Pop on the same edge that launches the ack, so each DATA read removes exactly one word.
    assign pop_ready     = rd_req & sel_data & pop_valid;
    assign overrun_clear = wr_en & sel_status & wb_dat_i[STAT_OVR];

    // Underflow bookkeeping: an empty DATA read sets, a STATUS write of bit2 clears.
    assign unf_set = rd_req & sel_data & ~pop_valid;
    assign unf_clr = wr_en & sel_status & wb_dat_i[STAT_UNF];

`ifdef ADC_FIFO_READER_CNT_EN
    logic [31:0] cnt_q;
    logic        cnt_clr;

    assign cnt_clr = wr_en & (ofs == ADC_RD_CNT_OFS);

    // Free-running pop counter; a clear coinciding with a pop leaves the count at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= pop_ready ? 32'd1 : 32'd0;
        end else if (pop_ready) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end
`endif

    // Read mux: values are captured at the request edge into the data register.
    always_comb begin
        rd_val = '0;
        case (ofs)
            ADC_RD_DATA_OFS: begin
                rd_val = pop_valid ? pop_data : EMPTY_VALUE;
            end
            ADC_RD_LEVEL_OFS: begin
                rd_val[LEVEL_W-1:0] = level_words;
            end
            ADC_RD_STATUS_OFS: begin
                rd_val[STAT_OVR]   = overrun_sticky;
                rd_val[STAT_VALID] = pop_valid;
                rd_val[STAT_UNF]   = unf_q;
            end
            ADC_RD_CNT_OFS: begin
`ifdef ADC_FIFO_READER_CNT_EN
                rd_val = cnt_q;
`else
                rd_val = '0;
`endif
            end
            default: begin
                rd_val = '0;
            end
        endcase
    end

    // Bus response registers: one-cycle ack pulse per request, read data latched on reads only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req;
            if (rd_req) begin
                dat_q <= rd_val;
            end
        end
    end

    // Sticky read-underflow flag; set takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            unf_q <= 1'b0;
        end else if (unf_set) begin
            unf_q <= 1'b1;
        end else if (unf_clr) begin
            unf_q <= 1'b0;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_adc_fifo_wb_reader.sv
// Self-checking bench for adc_fifo_wb_reader with a behavioural 8-deep FIFO on the pop side.
// Latency: expects every access acknowledged one cycle after the strobe.
// Backpressure: drives a held strobe to check the every-other-cycle service pattern.
module tb_adc_fifo_wb_reader;
    import adc_fifo_reader_pkg::*;

`ifdef ADC_FIFO_READER_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        pop_valid;
    logic [31:0] pop_data;
    logic        pop_ready;
    logic [3:0]  level_words;
    logic        overrun_sticky;
    logic        overrun_clear;

    always #5 clk = ~clk;

    adc_fifo_wb_reader #(.LEVEL_W(4), .EMPTY_VALUE(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_cyc_i       (wb_cyc_i),
        .wb_stb_i       (wb_stb_i),
        .wb_we_i        (wb_we_i),
        .wb_adr_i       (wb_adr_i),
        .wb_dat_i       (wb_dat_i),
        .wb_sel_i       (wb_sel_i),
        .wb_dat_o       (wb_dat_o),
        .wb_ack_o       (wb_ack_o),
        .pop_valid      (pop_valid),
        .pop_data       (pop_data),
        .pop_ready      (pop_ready),
        .level_words    (level_words),
        .overrun_sticky (overrun_sticky),
        .overrun_clear  (overrun_clear)
    );

    // Behavioural show-ahead FIFO, depth 8; independent of the reader's reset.
    logic [31:0] f_mem [8];
    logic [2:0]  f_rp  = 3'd0;
    logic [2:0]  f_wp  = 3'd0;
    logic [3:0]  f_cnt = 4'd0;
    logic        f_ovr = 1'b0;
    logic        push_vld = 1'b0;
    logic [31:0] push_dat = 32'h0;
    logic        f_pop, f_push;

    assign f_pop          = pop_ready && (f_cnt != 4'd0);
    assign f_push         = push_vld && (f_cnt != 4'd8);
    assign pop_valid      = (f_cnt != 4'd0);
    assign pop_data       = f_mem[f_rp];
    assign level_words    = f_cnt;
    assign overrun_sticky = f_ovr;

    always @(posedge clk) begin
        if (f_push) begin
            f_mem[f_wp] <= push_dat;
            f_wp        <= f_wp + 3'd1;
        end
        if (f_pop) f_rp <= f_rp + 3'd1;
        f_cnt <= f_cnt + {3'd0, f_push} - {3'd0, f_pop};
        if (push_vld && (f_cnt == 4'd8) && !f_pop) f_ovr <= 1'b1;
        else if (overrun_clear)                     f_ovr <= 1'b0;
    end

    // Strobe monitors.
    int pop_cnt = 0;
    int ovc_cnt = 0;
    always @(posedge clk) begin
        if (pop_ready)     pop_cnt <= pop_cnt + 1;
        if (overrun_clear) ovc_cnt <= ovc_cnt + 1;
    end

    int n_checks = 0;
    int n_errs   = 0;
    logic [31:0] exp_words [$];   // words pushed into the FIFO, in order
    logic [31:0] sb [$];          // expected read data per issued read
    int exp_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        @(negedge clk);
        push_vld = 1'b1;
        push_dat = d;
        if (f_cnt != 4'd8) exp_words.push_back(d);
        @(negedge clk);
        push_vld = 1'b0;
    endtask

    task automatic wb_rd(input logic [3:0] adr, input logic [31:0] exp, input string tag);
        int  lat;
        bit  got;
        sb.push_back(exp);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = adr;  wb_sel_i = 4'hF;
        lat = 0; got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (wb_ack_o) got = 1'b1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check_val({tag, "_ack_lat"}, got ? 32'(lat) : 32'hDEAD, 32'd1);
        check_val(tag, wb_dat_o, sb.pop_front());
    endtask

    task automatic data_rd(input string tag);
        logic [31:0] e;
        if (exp_words.size() != 0) begin
            e = exp_words.pop_front();
            exp_cnt++;
        end else begin
            e = 32'h0000_0000;
        end
        wb_rd(ADC_RD_DATA_OFS, e, tag);
    endtask

    task automatic wb_wr(input logic [3:0] adr, input logic [31:0] d, input string tag);
        bit got;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = adr;  wb_dat_i = d; wb_sel_i = 4'h1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (wb_ack_o) got = 1'b1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check_val({tag, "_ack"}, {31'd0, got}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, o0;
        rst = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 4'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0;
        repeat (3) @(negedge clk);
        // Reset state, with a DATA request presented during reset.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_sel_i = 4'hF;
        @(negedge clk);
        check_val("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check_val("rst_dat", wb_dat_o, 32'd0);
        check_val("rst_pop_ready", {31'd0, pop_ready}, 32'd0);
        check_val("rst_ovr_clear", {31'd0, overrun_clear}, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rst = 1'b0;

        // Three words read back in order, level decreasing.
        for (int i = 0; i < 3; i++) push_word(32'hA5A5_0000 + i);
        wb_rd(ADC_RD_LEVEL_OFS, 32'd3, "level3");
        data_rd("data0");
        wb_rd(ADC_RD_LEVEL_OFS, 32'd2, "level2");
        data_rd("data1");
        wb_rd(ADC_RD_LEVEL_OFS, 32'd1, "level1");
        data_rd("data2");
        wb_rd(ADC_RD_LEVEL_OFS, 32'd0, "level0");

        // Empty read: EMPTY_VALUE, no pop, underflow flagged then cleared.
        p0 = pop_cnt;
        data_rd("empty_data");
        check_val("empty_no_pop", 32'(pop_cnt - p0), 32'd0);
        wb_rd(ADC_RD_STATUS_OFS, 32'h4, "status_unf");
        wb_wr(ADC_RD_STATUS_OFS, 32'h4, "unf_clr");
        wb_rd(ADC_RD_STATUS_OFS, 32'h0, "status_clean");

        // Fill, overrun, clear the overrun with a single pulse.
        for (int i = 0; i < 9; i++) push_word(32'h1234_0000 + i);
        wb_rd(ADC_RD_LEVEL_OFS, 32'd8, "level_full");
        wb_rd(ADC_RD_STATUS_OFS, 32'h3, "status_ovr");
        o0 = ovc_cnt;
        wb_wr(ADC_RD_STATUS_OFS, 32'h1, "ovr_clr");
        check_val("ovr_clear_width", 32'(ovc_cnt - o0), 32'd1);
        wb_rd(ADC_RD_STATUS_OFS, 32'h2, "status_after_clr");
        for (int i = 0; i < 8; i++) data_rd("drain_full");

        // Held strobe on DATA for 6 cycles with 5 words queued.
        for (int i = 0; i < 5; i++) push_word(32'hBEEF_0000 + i);
        p0 = pop_cnt;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp_words.pop_front());
            exp_cnt++;
        end
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = ADC_RD_DATA_OFS; wb_sel_i = 4'hF;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            check_val($sformatf("stall_ack%0d", c), {31'd0, wb_ack_o}, {31'd0, c[0]});
            if (wb_ack_o && sb.size() != 0) check_val("stall_data", wb_dat_o, sb.pop_front());
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check_val("stall_pops", 32'(pop_cnt - p0), 32'd3);
        wb_rd(ADC_RD_LEVEL_OFS, 32'd2, "stall_level");
        data_rd("stall_drain0");
        data_rd("stall_drain1");

        // Write to DATA has no effect.
        push_word(32'hCAFE_0001);
        wb_wr(ADC_RD_DATA_OFS, 32'hFFFF_FFFF, "data_wr");
        wb_rd(ADC_RD_LEVEL_OFS, 32'd1, "level_after_data_wr");

        // Reset in the cycle of a DATA request: no ack, no pop, level kept.
        p0 = pop_cnt;
        @(negedge clk);
        rst = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = ADC_RD_DATA_OFS; wb_sel_i = 4'hF;
        check_val("midrst_pop_ready", {31'd0, pop_ready}, 32'd0);
        @(negedge clk);
        check_val("midrst_ack", {31'd0, wb_ack_o}, 32'd0);
        check_val("midrst_no_pop", 32'(pop_cnt - p0), 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rst = 1'b0;
        exp_cnt = 0;
        wb_rd(ADC_RD_LEVEL_OFS, 32'd1, "midrst_level");
        data_rd("midrst_data");

        // Pop counter register (reads 0 when not built in).
        for (int i = 0; i < 4; i++) push_word(32'h0C0C_0000 + i);
        for (int i = 0; i < 4; i++) data_rd("cnt_pop");
        wb_rd(ADC_RD_CNT_OFS, CNT_ON ? 32'(exp_cnt) : 32'd0, "cnt_value");
        wb_wr(ADC_RD_CNT_OFS, 32'h0, "cnt_clr");
        exp_cnt = 0;
        wb_rd(ADC_RD_CNT_OFS, CNT_ON ? 32'(exp_cnt) : 32'd0, "cnt_cleared");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
